// File: rtl/wt_mem_arbiter.sv
// Round-robin arbiter that funnels cache client requests into one memory port,
// tracks per-port outstanding requests and routes tagged returns back to the issuer.
module wt_mem_arbiter #(
  parameter int NumPorts          = 3,
  parameter int ClientTidWidth    = 2,
  parameter int MaxOutstanding    = 4,
  parameter int AddrWidth         = 64,
  parameter int DataWidth         = 64,
  localparam int PortIdxWidth     = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int MemTidWidth      = PortIdxWidth + ClientTidWidth
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [NumPorts-1:0]                      req_valid_i,
  output logic [NumPorts-1:0]                      req_ready_o,
  input  logic [NumPorts-1:0][AddrWidth-1:0]       req_addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]       req_data_i,
  input  logic [NumPorts-1:0]                      req_we_i,
  input  logic [NumPorts-1:0][ClientTidWidth-1:0]  req_tid_i,
  output logic                                     mem_req_valid_o,
  input  logic                                     mem_req_ready_i,
  output logic [AddrWidth-1:0]                     mem_req_addr_o,
  output logic [DataWidth-1:0]                     mem_req_data_o,
  output logic                                     mem_req_we_o,
  output logic [MemTidWidth-1:0]                   mem_req_tid_o,
  input  logic                                     mem_rtrn_valid_i,
  input  logic [MemTidWidth-1:0]                   mem_rtrn_tid_i,
  input  logic [DataWidth-1:0]                     mem_rtrn_data_i,
  output logic [NumPorts-1:0]                      rtrn_valid_o,
  output logic [ClientTidWidth-1:0]                rtrn_tid_o,
  output logic [DataWidth-1:0]                     rtrn_data_o,
  output logic                                     idle_o,
  output logic                                     err_o
);

  localparam logic [3:0]              MaxCnt   = 4'(MaxOutstanding);
  localparam logic [PortIdxWidth:0]   NumW     = (PortIdxWidth+1)'(NumPorts);
  localparam logic [PortIdxWidth-1:0] LastPort = PortIdxWidth'(NumPorts - 1);

  logic [PortIdxWidth-1:0]   rr_q;
  logic [PortIdxWidth-1:0]   gnt_idx;
  logic [PortIdxWidth:0]     cand;
  logic                      gnt_found;
  logic                      gnt_go;
  logic [NumPorts-1:0]       elig;
  logic [NumPorts-1:0]       gnt_oh;
  logic [NumPorts-1:0]       rtrn_hit;
  logic [3:0]                cnt_q [NumPorts];
  logic [PortIdxWidth-1:0]   rtrn_port;
  logic                      rtrn_bad;
  logic                      cnt_zero;

  logic                      req_vld_p1;
  logic [AddrWidth-1:0]      req_addr_p1;
  logic [DataWidth-1:0]      req_data_p1;
  logic                      req_we_p1;
  logic [MemTidWidth-1:0]    req_tid_p1;
  logic [NumPorts-1:0]       rtrn_vld_p1;
  logic [ClientTidWidth-1:0] rtrn_tid_p1;
  logic [DataWidth-1:0]      rtrn_data_p1;
  logic                      err_p1;

  // Stage p0: eligibility, circular search from rr_q, return decode
  always_comb begin
    elig      = '0;
    gnt_found = 1'b0;
    gnt_idx   = rr_q;
    cand      = '0;
    for (int i = 0; i < NumPorts; i++) begin
      elig[i] = req_valid_i[i] && (cnt_q[i] < MaxCnt);
    end
    for (int k = 0; k < NumPorts; k++) begin
      cand = {1'b0, rr_q} + (PortIdxWidth+1)'(k);
      if (cand >= NumW) cand = cand - NumW;
      if (!gnt_found && elig[cand[PortIdxWidth-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[PortIdxWidth-1:0];
      end
    end
  end

  // A grant is only issued if the output register is free this cycle.
  assign gnt_go    = gnt_found && (!req_vld_p1 || mem_req_ready_i) && !rst_i;
  assign rtrn_port = mem_rtrn_tid_i[MemTidWidth-1:ClientTidWidth];

  always_comb begin
    gnt_oh   = '0;
    rtrn_hit = '0;
    cnt_zero = 1'b1;
    for (int i = 0; i < NumPorts; i++) begin
      gnt_oh[i]   = gnt_go && (gnt_idx == PortIdxWidth'(i));
      rtrn_hit[i] = mem_rtrn_valid_i && (rtrn_port == PortIdxWidth'(i)) && (cnt_q[i] != 4'd0);
      if (cnt_q[i] != 4'd0) cnt_zero = 1'b0;
    end
    rtrn_bad = mem_rtrn_valid_i && !(|rtrn_hit);
  end

  // Stage p1: control registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q        <= '0;
      req_vld_p1  <= 1'b0;
      rtrn_vld_p1 <= '0;
      err_p1      <= 1'b0;
      for (int i = 0; i < NumPorts; i++) cnt_q[i] <= 4'd0;
    end else begin
      if (gnt_go) begin
        rr_q       <= (gnt_idx == LastPort) ? '0 : gnt_idx + PortIdxWidth'(1);
        req_vld_p1 <= 1'b1;
      end else if (mem_req_ready_i) begin
        req_vld_p1 <= 1'b0;
      end
      rtrn_vld_p1 <= rtrn_hit;
      err_p1      <= rtrn_bad;
      for (int i = 0; i < NumPorts; i++) begin
        case ({gnt_oh[i], rtrn_hit[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + 4'd1;
          2'b01:   cnt_q[i] <= cnt_q[i] - 4'd1;
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Stage p1: payload registers, qualified by their valids
  always_ff @(posedge clk_i) begin
    if (gnt_go) begin
      req_addr_p1 <= req_addr_i[gnt_idx];
      req_data_p1 <= req_data_i[gnt_idx];
      req_we_p1   <= req_we_i[gnt_idx];
      req_tid_p1  <= {gnt_idx, req_tid_i[gnt_idx]};
    end
    rtrn_tid_p1  <= mem_rtrn_tid_i[ClientTidWidth-1:0];
    rtrn_data_p1 <= mem_rtrn_data_i;
  end

  assign req_ready_o     = gnt_oh;
  assign mem_req_valid_o = req_vld_p1;
  assign mem_req_addr_o  = req_addr_p1;
  assign mem_req_data_o  = req_data_p1;
  assign mem_req_we_o    = req_we_p1;
  assign mem_req_tid_o   = req_tid_p1;
  assign rtrn_valid_o    = rtrn_vld_p1;
  assign rtrn_tid_o      = rtrn_tid_p1;
  assign rtrn_data_o     = rtrn_data_p1;
  assign err_o           = err_p1;
  assign idle_o          = !req_vld_p1 && cnt_zero;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// Scenario bench for wt_mem_arbiter: expected memory requests and client
// returns are queued as stimulus is driven and popped as the DUT emits them.
module tb_wt_mem_arbiter;

  logic              clk;
  logic              rst;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [2:0][63:0]  req_addr;
  logic [2:0][63:0]  req_data;
  logic [2:0]        req_we;
  logic [2:0][1:0]   req_tid;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [63:0]       mem_req_addr;
  logic [63:0]       mem_req_data;
  logic              mem_req_we;
  logic [3:0]        mem_req_tid;
  logic              mem_rtrn_valid;
  logic [3:0]        mem_rtrn_tid;
  logic [63:0]       mem_rtrn_data;
  logic [2:0]        rtrn_valid;
  logic [1:0]        rtrn_tid;
  logic [63:0]       rtrn_data;
  logic              idle;
  logic              err;

  typedef struct {
    logic [3:0]  tid;
    logic        we;
    logic [63:0] addr;
    logic [63:0] data;
  } req_t;

  typedef struct {
    logic [2:0]  vec;
    logic [1:0]  tid;
    logic [63:0] data;
  } rtrn_t;

  req_t  exp_req[$];
  rtrn_t exp_rtrn[$];
  req_t  mon_q;
  rtrn_t mon_r;
  int    n_tests = 0;
  int    n_fail  = 0;

  wt_mem_arbiter dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_addr_i      (req_addr),
    .req_data_i      (req_data),
    .req_we_i        (req_we),
    .req_tid_i       (req_tid),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_data_o  (mem_req_data),
    .mem_req_we_o    (mem_req_we),
    .mem_req_tid_o   (mem_req_tid),
    .mem_rtrn_valid_i(mem_rtrn_valid),
    .mem_rtrn_tid_i  (mem_rtrn_tid),
    .mem_rtrn_data_i (mem_rtrn_data),
    .rtrn_valid_o    (rtrn_valid),
    .rtrn_tid_o      (rtrn_tid),
    .rtrn_data_o     (rtrn_data),
    .idle_o          (idle),
    .err_o           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] addr_of(int p, int n);
    return {16'hADD0, 16'(p), 32'(n)};
  endfunction

  function automatic logic [63:0] data_of(int p, int n);
    return {16'hDA7A, 16'(n), 32'(p) ^ 32'h5A5A_0000};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(int p, int n);
    req_addr[p] = addr_of(p, n);
    req_data[p] = data_of(p, n);
    req_we[p]   = 1'(n);
    req_tid[p]  = 2'(n);
  endtask

  task automatic push_req(int p, int n);
    exp_req.push_back('{tid: {2'(p), 2'(n)}, we: 1'(n), addr: addr_of(p, n), data: data_of(p, n)});
  endtask

  // Scoreboard pop on the falling edge, where everything is settled.
  always @(negedge clk) begin
    if (!rst && mem_req_valid && mem_req_ready) begin
      n_tests++;
      if (exp_req.size() == 0) begin
        n_fail++;
        $display("FAIL mem_req_unexpected got tid=%h addr=%h want none", mem_req_tid, mem_req_addr);
      end else begin
        mon_q = exp_req.pop_front();
        if ({mem_req_tid, mem_req_we, mem_req_addr, mem_req_data} !== {mon_q.tid, mon_q.we, mon_q.addr, mon_q.data}) begin
          n_fail++;
          $display("FAIL mem_req got tid=%h we=%b addr=%h data=%h want tid=%h we=%b addr=%h data=%h",
                   mem_req_tid, mem_req_we, mem_req_addr, mem_req_data, mon_q.tid, mon_q.we, mon_q.addr, mon_q.data);
        end
      end
    end
    if (!rst && rtrn_valid !== 3'b000) begin
      n_tests++;
      if (exp_rtrn.size() == 0) begin
        n_fail++;
        $display("FAIL rtrn_unexpected got vec=%b tid=%h want none", rtrn_valid, rtrn_tid);
      end else begin
        mon_r = exp_rtrn.pop_front();
        if ({rtrn_valid, rtrn_tid, rtrn_data} !== {mon_r.vec, mon_r.tid, mon_r.data}) begin
          n_fail++;
          $display("FAIL rtrn got vec=%b tid=%h data=%h want vec=%b tid=%h data=%h",
                   rtrn_valid, rtrn_tid, rtrn_data, mon_r.vec, mon_r.tid, mon_r.data);
        end
      end
    end
  end

  task automatic apply_reset();
    rst            = 1'b1;
    req_valid      = '0;
    mem_req_ready  = 1'b0;
    mem_rtrn_valid = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0; mem_req_ready = 1'b0; mem_rtrn_valid = 1'b0;
    mem_rtrn_tid = '0; mem_rtrn_data = '0;
    for (int p = 0; p < 3; p++) set_port(p, 0);
    #1 rst = 1'b1;
    req_valid = 3'b111; mem_req_ready = 1'b1;
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_tests++;
      if ({mem_req_valid, req_ready, rtrn_valid, err, idle} !== 9'b0_000_000_0_1) begin
        n_fail++;
        $display("FAIL reset_state k=%0d got v=%b rdy=%b rv=%b err=%b idle=%b want v=0 rdy=000 rv=000 err=0 idle=1",
                 k, mem_req_valid, req_ready, rtrn_valid, err, idle);
      end
      cyc();
    end
    req_valid = '0; mem_rtrn_valid = 1'b0; mem_req_ready = 1'b0;
    rst = 1'b0;
    cyc();
    n_tests++;
    if (idle !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release got idle=%b v=%b want idle=1 v=0", idle, mem_req_valid);
    end
  endtask

  task automatic test_round_robin();
    int seq[3];
    int ep;
    apply_reset();
    for (int p = 0; p < 3; p++) begin seq[p] = 0; set_port(p, 0); end
    req_valid = 3'b111; mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ep = k % 3;
      #1;
      n_tests++;
      if (req_ready !== 3'(1 << ep)) begin
        n_fail++;
        $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, 3'(1 << ep));
      end
      push_req(ep, seq[ep]);
      cyc();
      seq[ep]++;
      set_port(ep, seq[ep]);
      n_tests++;
      if (mem_req_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_valid k=%0d got %b want 1", k, mem_req_valid);
      end
    end
    req_valid = '0;
    cyc();
    cyc();
  endtask

  task automatic test_max_outstanding();
    int grants = 0;
    int seq = 0;
    apply_reset();
    set_port(1, 0);
    req_valid = 3'b010; mem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (req_ready[1]) begin
        grants++;
        push_req(1, seq);
        cyc();
        seq++;
        set_port(1, seq);
      end else begin
        cyc();
      end
    end
    n_tests++;
    if (grants != 4 || req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL max_out got grants=%0d rdy=%b want grants=4 rdy=000", grants, req_ready);
    end
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b0111; mem_rtrn_data = 64'hDEAD_BEEF_0000_0001;
    exp_rtrn.push_back('{vec: 3'b010, tid: 2'd3, data: 64'hDEAD_BEEF_0000_0001});
    cyc();
    mem_rtrn_valid = 1'b0;
    n_tests++;
    if (rtrn_valid !== 3'b010 || rtrn_tid !== 2'd3) begin
      n_fail++;
      $display("FAIL max_out_rtrn got vec=%b tid=%0d want vec=010 tid=3", rtrn_valid, rtrn_tid);
    end
    #1;
    n_tests++;
    if (req_ready !== 3'b010) begin
      n_fail++;
      $display("FAIL max_out_regrant got %b want 010", req_ready);
    end
    push_req(1, seq);
    cyc();
    seq++;
    set_port(1, seq);
    #1;
    n_tests++;
    if (req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL max_out_block got %b want 000", req_ready);
    end
    req_valid = '0;
    cyc();
    cyc();
  endtask

  task automatic test_stall();
    apply_reset();
    set_port(0, 0);
    req_valid = 3'b001; mem_req_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL stall_first got %b want 001", req_ready);
    end
    push_req(0, 0);
    cyc();
    set_port(0, 1);
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== addr_of(0, 0) || mem_req_data !== data_of(0, 0) ||
          mem_req_tid !== 4'b0000 || req_ready !== 3'b000) begin
        n_fail++;
        $display("FAIL stall_hold k=%0d got v=%b addr=%h tid=%h rdy=%b want v=1 addr=%h tid=0 rdy=000",
                 k, mem_req_valid, mem_req_addr, mem_req_tid, req_ready, addr_of(0, 0));
      end
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 3'b001) begin
      n_fail++;
      $display("FAIL stall_drain_grant got %b want 001", req_ready);
    end
    push_req(0, 1);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
  endtask

  task automatic test_grant_return_same();
    int grants = 0;
    int seq;
    apply_reset();
    set_port(2, 0);
    req_valid = 3'b100; mem_req_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_tests++;
      if (req_ready !== 3'b100) begin
        n_fail++;
        $display("FAIL same_pre k=%0d got %b want 100", k, req_ready);
      end
      push_req(2, k);
      cyc();
      set_port(2, k + 1);
    end
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b1000; mem_rtrn_data = 64'h0123_4567_89AB_CDEF;
    exp_rtrn.push_back('{vec: 3'b100, tid: 2'd0, data: 64'h0123_4567_89AB_CDEF});
    #1;
    n_tests++;
    if (req_ready !== 3'b100) begin
      n_fail++;
      $display("FAIL same_grant got %b want 100", req_ready);
    end
    push_req(2, 2);
    cyc();
    mem_rtrn_valid = 1'b0;
    seq = 3;
    set_port(2, seq);
    for (int k = 0; k < 4; k++) begin
      #1;
      if (req_ready[2]) begin
        grants++;
        push_req(2, seq);
        cyc();
        seq++;
        set_port(2, seq);
      end else begin
        cyc();
      end
    end
    n_tests++;
    if (grants != 2) begin
      n_fail++;
      $display("FAIL same_count got further_grants=%0d want 2", grants);
    end
    req_valid = '0;
    cyc();
    cyc();
  endtask

  task automatic test_illegal();
    apply_reset();
    set_port(1, 0);
    req_valid = 3'b010; mem_req_ready = 1'b1;
    push_req(1, 0);
    cyc();
    req_valid = '0;
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b1101; mem_rtrn_data = 64'h1;
    cyc();
    mem_rtrn_valid = 1'b0;
    n_tests++;
    if (err !== 1'b1 || rtrn_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_port got err=%b rv=%b want err=1 rv=000", err, rtrn_valid);
    end
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b0010; mem_rtrn_data = 64'h2;
    cyc();
    mem_rtrn_valid = 1'b0;
    n_tests++;
    if (err !== 1'b1 || rtrn_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL illegal_zero got err=%b rv=%b want err=1 rv=000", err, rtrn_valid);
    end
    cyc();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse got err=%b want 0", err);
    end
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b0100; mem_rtrn_data = 64'h3;
    exp_rtrn.push_back('{vec: 3'b010, tid: 2'd0, data: 64'h3});
    cyc();
    mem_rtrn_valid = 1'b0;
    n_tests++;
    if (err !== 1'b0 || rtrn_valid !== 3'b010) begin
      n_fail++;
      $display("FAIL illegal_then_legal got err=%b rv=%b want err=0 rv=010", err, rtrn_valid);
    end
    cyc();
    n_tests++;
    if (idle !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_idle got %b want 1", idle);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    set_port(0, 0);
    req_valid = 3'b001; mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_req(0, k);
      cyc();
      set_port(0, k + 1);
    end
    req_valid = '0; mem_req_ready = 1'b0;
    #1;
    n_tests++;
    if (mem_req_valid !== 1'b1 || idle !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_held got v=%b idle=%b want v=1 idle=0", mem_req_valid, idle);
    end
    req_valid = 3'b111;
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_req_valid !== 1'b0 || idle !== 1'b1 || req_ready !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b idle=%b rdy=%b want v=0 idle=1 rdy=000", mem_req_valid, idle, req_ready);
    end
    exp_req.delete();
    req_valid = '0;
    cyc();
    rst = 1'b0;
    cyc();
    mem_rtrn_valid = 1'b1; mem_rtrn_tid = 4'b0000; mem_rtrn_data = 64'h4;
    cyc();
    mem_rtrn_valid = 1'b0;
    n_tests++;
    if (err !== 1'b1 || rtrn_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL mid_late_rtrn got err=%b rv=%b want err=1 rv=000", err, rtrn_valid);
    end
    cyc();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_late_pulse got err=%b want 0", err);
    end
  endtask

  task automatic test_drain();
    n_tests++;
    if (exp_req.size() != 0 || exp_rtrn.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_left got req=%0d rtrn=%0d want 0 0", exp_req.size(), exp_rtrn.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_max_outstanding();
    test_stall();
    test_grant_return_same();
    test_illegal();
    test_reset_mid();
    test_drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wt_mem_arbiter.md
WT_MEM_ARBITER -- requirements
Module: wt_mem_arbiter

Interface
REQ-001 SHALL have parameter NumPorts, default 3, number of cache client ports (2..8).
REQ-002 SHALL have parameter ClientTidWidth, default 2, width of the per-client transaction ID.
REQ-003 SHALL have parameter MaxOutstanding, default 4, maximum requests in flight per port (1..15).
REQ-004 SHALL have parameters AddrWidth and DataWidth, defaults 64 and 64, request address and data widths.
REQ-005 SHALL have derived PortIdxWidth = max(1, clog2(NumPorts)) and MemTidWidth = PortIdxWidth + ClientTidWidth.
REQ-006 clk_i  input  1  single clock, rising edge.
REQ-007 rst_i  input  1  asynchronous, active-high reset.
REQ-008 req_valid_i  input  NumPorts  per-port request valid.
REQ-009 req_ready_o  output  NumPorts  per-port request accept, one-hot or zero.
REQ-010 req_addr_i, req_data_i, req_we_i, req_tid_i  input  NumPorts x (AddrWidth, DataWidth, 1, ClientTidWidth)  per-port payload.
REQ-011 mem_req_valid_o  output  1  memory request valid.
REQ-012 mem_req_ready_i  input  1  memory accepts request.
REQ-013 mem_req_addr_o, mem_req_data_o, mem_req_we_o, mem_req_tid_o  output  AddrWidth, DataWidth, 1, MemTidWidth  memory payload.
REQ-014 mem_rtrn_valid_i, mem_rtrn_tid_i, mem_rtrn_data_i  input  1, MemTidWidth, DataWidth  memory return.
REQ-015 rtrn_valid_o  output  NumPorts  per-port return strobe.
REQ-016 rtrn_tid_o, rtrn_data_o  output  ClientTidWidth, DataWidth  shared return payload.
REQ-017 idle_o  output  1  no request held and all outstanding counters zero.
REQ-018 err_o  output  1  one-cycle pulse on an illegal return.

Function
REQ-019 Eligibility: port i is eligible when req_valid_i[i] is high and outstanding count[i] < MaxOutstanding.
REQ-020 Arbitration: round-robin starting at pointer rr_q; lowest index at or after rr_q wins, with wrap from NumPorts-1 to 0.
REQ-021 Grant: the winner's req_ready_o is high in the same cycle only when the output register is empty or is draining that cycle (mem_req_ready_i high); otherwise all req_ready_o are low.
REQ-022 On grant of port g: rr_q <= (g+1) mod NumPorts; without a grant, rr_q holds.
REQ-023 Output register: the granted payload is loaded one cycle after grant; mem_req_tid_o = {g, req_tid_i[g]}.
REQ-024 mem_req_valid_o and the payload hold stable until mem_req_ready_i is high; back-to-back grants sustain one request per cycle.
REQ-025 Counter: count[g] increments on grant; it is 4 bits wide.
REQ-026 A legal return on port p decrements count[p].
REQ-027 When a grant and a legal return hit the same port in the same cycle, the counter is unchanged.
REQ-028 Return routing: port p = mem_rtrn_tid_i[MemTidWidth-1:ClientTidWidth].
REQ-029 One cycle after mem_rtrn_valid_i, rtrn_valid_o[p] is high, with rtrn_tid_o = low ClientTidWidth bits and rtrn_data_o = registered data.
REQ-030 Illegal return: p >= NumPorts, or count[p] == 0. The return is dropped with no rtrn_valid_o, no counter change, and err_o pulses high one cycle later.
REQ-031 Returns are accepted every cycle with no backpressure; clients must always sink returns.
REQ-032 idle_o is combinational: !mem_req_valid_o and all count == 0.
REQ-033 Requests are issued out of order across ports and in order within a port; return order is unconstrained.

Reset
REQ-034 While rst_i is high, the following hold asynchronously: mem_req_valid_o=0, req_ready_o=0, rtrn_valid_o=0, err_o=0, all counts=0, rr_q=0, idle_o=1.
REQ-035 Reset mid-operation discards the held request and all in-flight accounting; returns arriving after reset release are treated as illegal (REQ-030).
REQ-036 Payload registers need no reset; their values are don't-care while the corresponding valid is low.

Verification
REQ-037 All 3 ports valid continuously, mem_req_ready_i=1 -> grants in order 0,1,2,0,1,2; mem_req_tid_o[3:2]=0,1,2 repeating; one request per cycle.
REQ-038 Port 1 only, MaxOutstanding=4, no returns -> exactly 4 grants, then req_ready_o[1]=0; one return with tid {1,2'b11} -> rtrn_valid_o[1] next cycle with rtrn_tid_o=3, followed by one further grant.
REQ-039 mem_req_ready_i=0 for 5 cycles with port 0 valid -> mem_req_valid_o high and payload stable for all 5 cycles; no second grant until ready rises.
REQ-040 Grant and return on port 2 in the same cycle with count[2]=2 -> count[2] stays 2.
REQ-041 Return with tid port field 3 (NumPorts=3), or to port 0 with count 0 -> err_o high for exactly one cycle; no rtrn_valid_o; counters unchanged.
REQ-042 Assert rst_i while 2 requests are in flight and one is held -> mem_req_valid_o drops immediately and idle_o=1; a late return after release -> err_o pulse.
